// File: rtl/fxp_resize_pipe.sv
// Fixed-point resize pipeline: Q(WI_IN.WF_IN) -> Q(WI_OUT.WF_OUT), two stages.
// Stage 1 aligns/rounds the fraction, stage 2 resizes the integer part and
// saturates or wraps. Valid/ready handshake on both sides.
// Optional build macro FXP_RESIZE_OVF_CNT_EN adds the 16-bit ovf_count output.
module fxp_resize_pipe #(
  parameter int WI_IN  = 5,
  parameter int WF_IN  = 11,
  parameter int WI_OUT = 6,
  parameter int WF_OUT = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WI_IN+WF_IN-1:0]   in_data,
  input  logic [1:0]               round_mode,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WI_OUT+WF_OUT-1:0] out_data,
  output logic                     out_ovf,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
`ifdef FXP_RESIZE_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int WIN  = WI_IN + WF_IN;
  localparam int WOUT = WI_OUT + WF_OUT;
  // One extra integer bit so a rounding carry out of the top is kept.
  localparam int WR   = WI_IN + WF_OUT + 1;
  // Wide enough to hold both the rounded value and the output, plus a sign.
  localparam int WC   = ((WR > WOUT) ? WR : WOUT) + 1;

  logic                 s1_valid;
  logic signed [WR-1:0] s1_val;
  logic                 s1_sat;
  logic                 s2_adv;
  logic                 s1_load;
  logic signed [WR-1:0] rnd;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_adv;
  assign in_ready = !reset && s1_load;

  generate
    if (WF_OUT >= WF_IN) begin : g_extend
      localparam int SH = WF_OUT - WF_IN;
      logic signed [WR-1:0] ext;

      // Widening the fraction is exact: sign-extend, then append zero LSBs.
      assign ext = {{(WR-WIN){in_data[WIN-1]}}, in_data};
      assign rnd = ext <<< SH;
    end else begin : g_round
      localparam int D = WF_IN - WF_OUT;
      logic signed [WR-1:0] trunc;
      logic [D-1:0]         frac;
      logic [D-1:0]         frac_lo;
      logic                 half;
      logic                 below_half;
      logic                 inc;

      // Floor of the value in output LSB units (arithmetic shift by D).
      assign trunc      = {in_data[WIN-1], in_data[WIN-1:D]};
      assign frac       = in_data[D-1:0];
      // Shifting out the half bit leaves only the bits below it.
      assign frac_lo    = frac << 1;
      assign half       = frac[D-1];
      assign below_half = |frac_lo;

      // Round-up decision; an exact tie in convergent mode goes to even.
      always_comb begin
        inc = 1'b0;
        case (round_mode)
          2'b01:   inc = half;
          2'b10:   inc = half && (below_half || trunc[0]);
          default: inc = 1'b0;
        endcase
      end

      assign rnd = trunc + {{(WR-1){1'b0}}, inc};
    end
  endgenerate

  // Stage 1 register: rounded value plus the sat_en captured with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_sat   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val <= rnd;
        s1_sat <= sat_en;
      end
    end
  end

  logic signed [WC-1:0] s2_wide;
  logic [WC-WOUT:0]     s2_top;
  logic                 s2_ovf;
  logic [WOUT-1:0]      s2_res;

  assign s2_wide = {{(WC-WR){s1_val[WR-1]}}, s1_val};
  // Representable iff every bit from the output sign bit upward matches.
  assign s2_top  = s2_wide[WC-1:WOUT-1];
  assign s2_ovf  = !((&s2_top) || !(|s2_top));

  // Integer resize: keep low bits, or clamp to the extreme code on overflow.
  always_comb begin
    s2_res = s2_wide[WOUT-1:0];
    if (s2_ovf && s1_sat) begin
      s2_res = s2_wide[WC-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
    end
  end

  // Stage 2 / output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_res;
        out_ovf  <= s2_ovf;
      end
    end
  end

  logic ovf_xfer;
  assign ovf_xfer = out_valid && out_ready && out_ovf;

  // Sticky overflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_xfer) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

`ifdef FXP_RESIZE_OVF_CNT_EN
  // Saturating count of overflowing transfers; increment beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (ovf_xfer) begin
      if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fxp_resize_pipe.sv
// Self-checking bench for fxp_resize_pipe at Q5.11 -> Q4.8.
// Expected outputs come from an arithmetic reference model (or literals);
// one negedge process compares every transfer and tracks the sticky flag.
module tb_fxp_resize_pipe;

  typedef struct {
    logic [11:0] d;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  round_mode = '0;
  logic        sat_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic        out_ovf;
  logic        ovf_sticky;
  logic        ovf_clr = 1'b0;
`ifdef FXP_RESIZE_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;
  exp_t expq[$];
  int rdy_mode = 0;

  fxp_resize_pipe #(
    .WI_IN(5), .WF_IN(11), .WI_OUT(4), .WF_OUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .round_mode(round_mode),
    .sat_en(sat_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr)
`ifdef FXP_RESIZE_OVF_CNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    return e;
  endfunction

  // Reference: value x/2^11 rounded to 1/2^8 steps, then fitted to 12-bit signed.
  function automatic exp_t model(input logic [15:0] x, input logic [1:0] m, input logic s);
    exp_t e;
    int v, tr, rem, r;
    logic [31:0] rr;
    v   = $signed(x);
    tr  = v >>> 3;
    rem = v - tr * 8;
    r   = tr;
    if (m == 2'd1 && rem >= 4) r = tr + 1;
    if (m == 2'd2 && (rem > 4 || (rem == 4 && (tr % 2) != 0))) r = tr + 1;
    rr  = r;
    e.o = (r < -2048) || (r > 2047);
    if (e.o && s) e.d = (r < 0) ? 12'h800 : 12'h7FF;
    else          e.d = rr[11:0];
    return e;
  endfunction

  function automatic logic [15:0] rand_x();
    logic [15:0] x;
    case ($urandom_range(0, 3))
      0:       x = 16'($urandom);
      1:       x = 16'($urandom_range(0, 31)) - 16'd16;
      2:       x = 16'h3FF0 + 16'($urandom_range(0, 31));
      default: x = 16'hBFF0 + 16'($urandom_range(0, 31));
    endcase
    return x;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [15:0] x, input logic [1:0] m, input logic s,
                      input exp_t e, output int stalls);
    bit acc;
    acc = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_data = x;
    round_mode = m;
    sat_en = s;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        expq.push_back(e);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!acc && stalls > 200) begin
        chk("send_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] x, input logic [1:0] m, input logic s);
    int st;
    send(x, m, s, model(x, m, s), st);
  endtask

  task automatic send_l(input logic [15:0] x, input logic [1:0] m, input logic s,
                        input logic [11:0] d, input logic o);
    int st;
    send(x, m, s, mk(d, o), st);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && expq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  // Downstream ready generator: 0 always, 1 never, 2 random, 3 pattern 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int pi;
    pat = 4'b1001;
    pi = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[pi];
          pi = (pi + 1) % 4;
        end
      endcase
    end
  end

  // Output checker: transfers vs expected queue, hold-while-stalled, sticky model.
  logic        prev_stall = 1'b0;
  logic [11:0] prev_d = '0;
  logic        prev_o = 1'b0;
  logic        m_sticky = 1'b0;
  int          m_count = 0;

  always @(negedge clk) begin
    exp_t e;
    logic xfer, e_ovf;
    chk("ovf_sticky", ovf_sticky, m_sticky);
`ifdef FXP_RESIZE_OVF_CNT_EN
    chk("ovf_count", ovf_count, 32'(m_count));
`endif
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_d);
      chk("hold_ovf", out_ovf, prev_o);
    end
    xfer = !reset && out_valid && out_ready;
    e_ovf = 1'b0;
    if (xfer) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ovf", out_ovf, e.o);
        e_ovf = e.o;
      end
    end
    if (reset) begin
      m_sticky = 1'b0;
      m_count = 0;
    end else if (xfer && e_ovf) begin
      m_sticky = 1'b1;
      if (m_count < 65535) m_count++;
    end else if (ovf_clr) begin
      m_sticky = 1'b0;
      m_count = 0;
    end
    prev_stall = !reset && out_valid && !out_ready;
    prev_d = out_data;
    prev_o = out_ovf;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int st, tot;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_ready_during_reset", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 12'h000);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_ovf_sticky", ovf_sticky, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Two-cycle latency on an empty pipe
    send_l(16'h0004, 2'd1, 1'b0, 12'h001, 1'b0);
    @(negedge clk);
    chk("latency_cycle1", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_cycle2", out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain();

    // Hand-computed corner cases
    send_l(16'h7FFF, 2'd0, 1'b1, 12'h7FF, 1'b1);
    send_l(16'h7FFF, 2'd0, 1'b0, 12'hFFF, 1'b1);
    send_l(16'h0004, 2'd0, 1'b0, 12'h000, 1'b0);
    send_l(16'h0004, 2'd1, 1'b0, 12'h001, 1'b0);
    send_l(16'h0004, 2'd2, 1'b0, 12'h000, 1'b0);
    send_l(16'h000C, 2'd2, 1'b0, 12'h002, 1'b0);
    send_l(16'h0004, 2'd3, 1'b0, 12'h000, 1'b0);
    send_l(16'hFFFC, 2'd0, 1'b0, 12'hFFF, 1'b0);
    send_l(16'hFFFC, 2'd2, 1'b0, 12'h000, 1'b0);
    send_l(16'hFFF4, 2'd2, 1'b0, 12'hFFE, 1'b0);
    send_l(16'h3FFF, 2'd0, 1'b1, 12'h7FF, 1'b0);
    send_l(16'h3FFF, 2'd1, 1'b1, 12'h7FF, 1'b1);
    send_l(16'h3FFF, 2'd1, 1'b0, 12'h800, 1'b1);
    send_l(16'hC000, 2'd0, 1'b1, 12'h800, 1'b0);
    send_l(16'h8000, 2'd0, 1'b1, 12'h800, 1'b1);
    drain();
    @(negedge clk);
    chk("sticky_after_ovf", ovf_sticky, 1'b1);
    @(posedge clk);
    #1;
    pulse_clr();
    @(negedge clk);
    chk("sticky_after_clr", ovf_sticky, 1'b0);
    @(posedge clk);
    #1;

`ifdef FXP_RESIZE_OVF_CNT_EN
    // Three overflow transfers counted, then cleared
    for (int i = 0; i < 3; i++) send_l(16'h7FFF, 2'd0, 1'b1, 12'h7FF, 1'b1);
    drain();
    @(negedge clk);
    chk("count_three", ovf_count, 16'd3);
    @(posedge clk);
    #1;
    pulse_clr();
    @(negedge clk);
    chk("count_cleared", ovf_count, 16'd0);
    @(posedge clk);
    #1;
`endif

    // Full throughput with downstream always ready
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] x;
      logic [1:0] m;
      logic s;
      x = rand_x();
      m = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      send(x, m, s, model(x, m, s), st);
      tot += st;
    end
    chk("throughput_stalls", 32'(tot), 32'd0);
    drain();

    // Eight samples against a 1,0,0,1 ready pattern
    rdy_mode = 3;
    for (int i = 0; i < 8; i++) send_m(rand_x(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain();

    // Randomized traffic with random backpressure, gaps and clears
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_m(rand_x(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        ovf_clr = ($urandom_range(0, 4) == 0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
      end
    end
    rdy_mode = 0;
    drain();

    // Reset with two samples in flight
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_m(16'h1234, 2'd0, 1'b0);
    send_m(16'h0567, 2'd1, 1'b1);
    reset = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("in_ready_mid_reset", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1'b1);
    chk("out_valid_after_reset", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_output_after_reset", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
